// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver (sync + run-length filter + 11-bit frame deserialiser).
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity; otherwise only the stop bit is checked.
module ps2_kbd_rx #(
  parameter int FILTER      = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] kdata,
  output logic       kdone,
  output logic       kerr
);
  localparam int CW = $clog2(FILTER);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0] raw, f;
  assign raw = {ps2_dat, ps2_clk};
  // bit 0 = clock line, bit 1 = data line; both idle high out of reset
  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic s1, s2, fl;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        fl  <= 1'b1;
        cnt <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == fl) cnt <= '0;
        else if (cnt == CW'(FILTER - 1)) begin
          fl  <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    assign f[i] = fl;
  end
  state_t      state, state_n;
  logic        clk_q, fall, dat;
  logic [7:0]  sreg, sreg_n, kdata_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic        par_ok, par_n, kdone_n, kerr_n;
  logic [15:0] tcnt, tcnt_n;
  assign fall = clk_q & ~f[0];
  assign dat  = f[1];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      clk_q  <= 1'b1;
      sreg   <= '0;
      bitcnt <= '0;
      par_ok <= 1'b0;
      tcnt   <= '0;
      kdata  <= '0;
      kdone  <= 1'b0;
      kerr   <= 1'b0;
    end else begin
      state  <= state_n;
      clk_q  <= f[0];
      sreg   <= sreg_n;
      bitcnt <= bitcnt_n;
      par_ok <= par_n;
      tcnt   <= tcnt_n;
      kdata  <= kdata_n;
      kdone  <= kdone_n;
      kerr   <= kerr_n;
    end
  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    bitcnt_n = bitcnt;
    par_n    = par_ok;
    kdata_n  = kdata;
    kdone_n  = 1'b0;
    kerr_n   = 1'b0;
    tcnt_n   = (fall || state == IDLE) ? '0 : tcnt + 16'd1;
    if (fall) begin
      case (state)
        IDLE: if (!dat) begin
          state_n  = DATA;
          bitcnt_n = '0;
        end
        DATA: begin
          sreg_n   = {dat, sreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          state_n  = (bitcnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_n = ^sreg ^ dat;
`else
          par_n = 1'b1;
`endif
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          kdone_n = dat & par_ok;
          kerr_n  = ~(dat & par_ok);
          kdata_n = (dat & par_ok) ? sreg : kdata;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == 16'(TIMEOUT_CYC - 1)) begin
      // a fall in the same cycle takes precedence, hence the else
      state_n = IDLE;
      kerr_n  = 1'b1;
      tcnt_n  = '0;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed PS/2 frames with a scoreboard of expected kdone/kerr pulses, values and arrival cycles.
module tb_ps2_kbd_rx;
  localparam int F    = 8;
  localparam int TO   = 300;
  localparam int HALF = 20;
  localparam int LAT  = F + 3;
  logic       clock = 1'b0, reset_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [7:0] kdata;
  logic       kdone, kerr;
  int checks = 0, errors = 0, cyc = 0, t_last = 0, ndone = 0;
  logic prev = 1'b0;
  logic [7:0] model_kdata = 8'h00;
  typedef struct {logic err; logic [7:0] data; int t;} ev_t;
  ev_t q[$];

  ps2_kbd_rx #(.FILTER(F), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .kdata(kdata), .kdone(kdone), .kerr(kerr)
  );

  always #20 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic err, input logic [7:0] data, input int t);
    ev_t e;
    if (!err) model_kdata = data;
    e.err = err;
    e.data = model_kdata;
    e.t = t;
    q.push_back(e);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, ~^d ^ flip, d, 1'b0};
  endfunction

  task automatic send(input logic [10:0] fr, input int n);
    logic good;
`ifdef PS2_PARITY_CHECK_EN
    good = fr[10] & ^fr[9:1];
`else
    good = fr[10];
`endif
    for (int b = 0; b < n; b++) begin
      ps2_dat = fr[b];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      t_last = cyc;
      if (n == 11 && b == 10) expect_ev(~good, fr[8:1], t_last + LAT);
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  always @(negedge clock) begin
    if (kdone | kerr) begin
      ev_t e;
      chk("both_high", {31'd0, kdone & kerr}, 32'd0);
      chk("back_to_back", {31'd0, prev}, 32'd0);
      chk("pending", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("kerr", {31'd0, kerr}, {31'd0, e.err});
        chk("kdone", {31'd0, kdone}, {31'd0, ~e.err});
        chk("kdata", {24'd0, kdata}, {24'd0, e.data});
        chk("cycle", cyc, e.t);
      end
      if (kdone) ndone++;
    end
    prev = kdone | kerr;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_kdata", {24'd0, kdata}, 32'd0);
    chk("rst_kdone", {31'd0, kdone}, 32'd0);
    chk("rst_kerr", {31'd0, kerr}, 32'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    send(mk(8'h1C, 1'b0, 1'b1), 11);
    send(mk(8'h1C, 1'b1, 1'b1), 11);
    send(mk(8'h5A, 1'b0, 1'b0), 11);
    repeat (30) @(negedge clock);
    send(mk(8'h37, 1'b0, 1'b1), 6);
    expect_ev(1'b1, 8'h00, t_last + LAT + TO);
    repeat (TO + 40) @(negedge clock);
    chk("timeout_seen", q.size(), 32'd0);
    send(mk(8'h1C, 1'b0, 1'b1), 11);
    repeat (30) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clock);
    chk("glitch_quiet", q.size(), 32'd0);
    send(mk(8'hF0, 1'b0, 1'b1), 11);
    send(mk(8'h1C, 1'b0, 1'b1), 11);
    repeat (30) @(negedge clock);
    send(mk(8'h29, 1'b0, 1'b1), 5);
    reset_n = 1'b0;
    model_kdata = 8'h00;
    @(negedge clock);
    chk("midrst_kdata", {24'd0, kdata}, 32'd0);
    chk("midrst_kdone", {31'd0, kdone}, 32'd0);
    chk("midrst_kerr", {31'd0, kerr}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    send(mk(8'h29, 1'b0, 1'b1), 11);
    repeat (TO + 50) @(negedge clock);
    chk("drain", q.size(), 32'd0);
`ifdef PS2_PARITY_CHECK_EN
    chk("kdone_count", ndone, 32'd5);
`else
    chk("kdone_count", ndone, 32'd6);
`endif
    chk("final_kdata", {24'd0, kdata}, 32'h29);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
